// File: rtl/v_pkg.sv
// rtl/v_pkg.sv - shared payload types for update commands
package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [1:0]  cmd_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] size_t;
endpackage

// File: rtl/v_upd_ingress.sv
// rtl/v_upd_ingress.sv - update command buffer feeding the list engine
// Commands queue from reset onward; issue waits until the engine finishes its busy-high/low init handshake.
module v_upd_ingress #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_in_vld,
    input  v_pkg::id_t                 i_in_prod_id,
    input  v_pkg::cmd_t                i_in_cmd,
    input  v_pkg::key_t                i_in_key,
    input  v_pkg::size_t               i_in_size,
    output logic                       o_in_rdy_r,
    input  logic                       i_busy_r,
    output logic                       o_upd_vld_r,
    output v_pkg::id_t                 o_upd_prod_id_r,
    output v_pkg::cmd_t                o_upd_cmd_r,
    output v_pkg::key_t                o_upd_key_r,
    output v_pkg::size_t               o_upd_size_r,
    output logic [$clog2(DEPTH):0]     o_level_r,
    output logic                       o_ovf_r
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_INIT_HI, S_INIT_LO, S_RUN} state_t;

    typedef struct packed {
        v_pkg::id_t   prod_id;
        v_pkg::cmd_t  cmd;
        v_pkg::key_t  key;
        v_pkg::size_t size;
    } entry_t;

    state_t          state_r;
    state_t          state_nxt;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic            push;
    logic            pop;
    logic [LW-1:0]   level_nxt;

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_INIT_HI: if (i_busy_r)  state_nxt = S_INIT_LO;
            S_INIT_LO: if (!i_busy_r) state_nxt = S_RUN;
            S_RUN:     state_nxt = S_RUN;
            default:   state_nxt = S_INIT_HI;
        endcase
    end

    // Pop reads the registered level only, so an entry pushed this cycle can never leave this cycle.
    assign push      = i_in_vld && o_in_rdy_r;
    assign pop       = (state_r == S_RUN) && !i_busy_r && (o_level_r != '0);
    assign level_nxt = o_level_r + LW'(push) - LW'(pop);
    assign head      = mem[rd_ptr_r];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_r] <= '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_INIT_HI;
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            o_level_r       <= '0;
            o_in_rdy_r      <= 1'b0;
            o_ovf_r         <= 1'b0;
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_cmd_r     <= '0;
            o_upd_key_r     <= '0;
            o_upd_size_r    <= '0;
        end else begin
            state_r     <= state_nxt;
            o_level_r   <= level_nxt;
            o_in_rdy_r  <= (level_nxt <= LW'(DEPTH - 1));
            o_upd_vld_r <= pop;
            if (i_in_vld && !o_in_rdy_r) begin
                o_ovf_r <= 1'b1;
            end
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r        <= rd_ptr_r + AW'(1);
                o_upd_prod_id_r <= head.prod_id;
                o_upd_cmd_r     <= head.cmd;
                o_upd_key_r     <= head.key;
                o_upd_size_r    <= head.size;
            end
        end
    end
endmodule

// File: tb/tb_v_upd_ingress.sv
// tb/tb_v_upd_ingress.sv - self-checking bench for v_upd_ingress
module tb_v_upd_ingress;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_in_vld;
    v_pkg::id_t   i_in_prod_id;
    v_pkg::cmd_t  i_in_cmd;
    v_pkg::key_t  i_in_key;
    v_pkg::size_t i_in_size;
    logic         o_in_rdy_r;
    logic         i_busy_r;
    logic         o_upd_vld_r;
    v_pkg::id_t   o_upd_prod_id_r;
    v_pkg::cmd_t  o_upd_cmd_r;
    v_pkg::key_t  o_upd_key_r;
    v_pkg::size_t o_upd_size_r;
    logic [3:0]   o_level_r;
    logic         o_ovf_r;

    logic [41:0]  sb [$];
    int           vcyc [$];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    int           max_level = 0;

    always #5 clk = ~clk;

    v_upd_ingress #(.DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_in_vld        (i_in_vld),
        .i_in_prod_id    (i_in_prod_id),
        .i_in_cmd        (i_in_cmd),
        .i_in_key        (i_in_key),
        .i_in_size       (i_in_size),
        .o_in_rdy_r      (o_in_rdy_r),
        .i_busy_r        (i_busy_r),
        .o_upd_vld_r     (o_upd_vld_r),
        .o_upd_prod_id_r (o_upd_prod_id_r),
        .o_upd_cmd_r     (o_upd_cmd_r),
        .o_upd_key_r     (o_upd_key_r),
        .o_upd_size_r    (o_upd_size_r),
        .o_level_r       (o_level_r),
        .o_ovf_r         (o_ovf_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were applied at the previous negedge; outputs are sampled at the next negedge.
    task automatic tick();
        logic [41:0] exp;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (int'(o_level_r) > max_level) max_level = int'(o_level_r);
        if (o_upd_vld_r === 1'b1) begin
            vcyc.push_back(cyc);
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("payload", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}), 64'(exp));
            end
        end
    endtask

    task automatic drive(input logic [7:0] id, input logic [1:0] cmd, input logic [15:0] key, input logic [15:0] size);
        i_in_vld     = 1'b1;
        i_in_prod_id = id;
        i_in_cmd     = cmd;
        i_in_key     = key;
        i_in_size    = size;
        if (o_in_rdy_r === 1'b1) sb.push_back({id, cmd, key, size});
        tick();
        i_in_vld = 1'b0;
    endtask

    task automatic reset_to_run();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        i_busy_r = 1'b1;
        tick();
        i_busy_r = 1'b0;
        tick();
    endtask

    initial begin
        int c;
        int n1;
        int n4;
        rst          = 1'b1;
        i_in_vld     = 1'b0;
        i_in_prod_id = '0;
        i_in_cmd     = '0;
        i_in_key     = '0;
        i_in_size    = '0;
        i_busy_r     = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_rdy", 64'(o_in_rdy_r), 64'd0);
        chk("rst_vld", 64'(o_upd_vld_r), 64'd0);
        chk("rst_level", 64'(o_level_r), 64'd0);
        chk("rst_ovf", 64'(o_ovf_r), 64'd0);
        chk("rst_payload", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}), 64'd0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", 64'(o_in_rdy_r), 64'd1);

        // Commands buffered during the engine init handshake
        drive(8'd1, 2'd0, 16'h0101, 16'h0011);
        drive(8'd2, 2'd1, 16'h0202, 16'h0022);
        drive(8'd3, 2'd2, 16'h0303, 16'h0033);
        chk("init_level", 64'(o_level_r), 64'd3);
        vcyc.delete();
        i_busy_r = 1'b1;
        repeat (4) tick();
        chk("init_no_early", 64'(vcyc.size()), 64'd0);
        i_busy_r = 1'b0;
        c = cyc;
        repeat (5) tick();
        chk("init_count", 64'(vcyc.size()), 64'd3);
        if (vcyc.size() == 3) begin
            chk("init_first", 64'(vcyc[0]), 64'(c + 2));
            chk("init_second", 64'(vcyc[1]), 64'(c + 3));
            chk("init_third", 64'(vcyc[2]), 64'(c + 4));
        end
        chk("init_sb_empty", 64'(sb.size()), 64'd0);

        // Two-cycle latency into an empty FIFO
        vcyc.delete();
        c = cyc;
        drive(8'd5, 2'd1, 16'h0010, 16'h0040);
        chk("lat_n1_vld", 64'(o_upd_vld_r), 64'd0);
        tick();
        chk("lat_n2_vld", 64'(o_upd_vld_r), 64'd1);
        chk("lat_n2_id", 64'(o_upd_prod_id_r), 64'd5);
        chk("lat_n2_key", 64'(o_upd_key_r), 64'h10);
        tick();
        chk("lat_n3_vld", 64'(o_upd_vld_r), 64'd0);
        chk("lat_hold_id", 64'(o_upd_prod_id_r), 64'd5);
        chk("lat_count", 64'(vcyc.size()), 64'd1);
        if (vcyc.size() == 1) chk("lat_cycle", 64'(vcyc[0]), 64'(c + 2));

        // Fill to DEPTH with the engine busy, then overflow
        i_busy_r = 1'b1;
        for (int i = 0; i < 8; i++) drive(8'(16 + i), 2'(i), 16'(16'hA000 + i), 16'(i * 3));
        chk("full_level", 64'(o_level_r), 64'd8);
        chk("full_rdy", 64'(o_in_rdy_r), 64'd0);
        chk("full_ovf_clear", 64'(o_ovf_r), 64'd0);
        drive(8'hEE, 2'd3, 16'hDEAD, 16'hBEEF);
        chk("ovf_set", 64'(o_ovf_r), 64'd1);
        chk("ovf_level", 64'(o_level_r), 64'd8);
        i_busy_r = 1'b0;
        repeat (11) tick();
        chk("full_drained", 64'(sb.size()), 64'd0);
        chk("full_level_zero", 64'(o_level_r), 64'd0);
        chk("ovf_sticky", 64'(o_ovf_r), 64'd1);

        // Streaming across pointer wrap
        reset_to_run();
        chk("stream_ovf_reset", 64'(o_ovf_r), 64'd0);
        vcyc.delete();
        max_level = 0;
        for (int i = 0; i < 20; i++) drive(8'(64 + i), 2'(i + 1), 16'(16'h5000 + i * 7), 16'(100 + i));
        repeat (4) tick();
        chk("stream_count", 64'(vcyc.size()), 64'd20);
        chk("stream_level_max", 64'(max_level <= 2), 64'd1);
        chk("stream_ovf", 64'(o_ovf_r), 64'd0);
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Busy pulse in the middle of a drain
        i_busy_r = 1'b1;
        for (int i = 0; i < 6; i++) drive(8'(128 + i), 2'(i), 16'(16'h7700 + i), 16'(i));
        chk("mid_level", 64'(o_level_r), 64'd6);
        vcyc.delete();
        i_busy_r = 1'b0;
        repeat (2) tick();
        i_busy_r = 1'b1;
        repeat (3) tick();
        i_busy_r = 1'b0;
        repeat (8) tick();
        chk("mid_count", 64'(vcyc.size()), 64'd6);
        n1 = 0;
        n4 = 0;
        for (int i = 1; i < vcyc.size(); i++) begin
            if (vcyc[i] - vcyc[i-1] == 1) n1++;
            if (vcyc[i] - vcyc[i-1] == 4) n4++;
        end
        chk("mid_gap3", 64'(n4), 64'd1);
        chk("mid_consecutive", 64'(n1), 64'd4);
        chk("mid_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with entries buffered
        i_busy_r = 1'b1;
        for (int i = 0; i < 4; i++) drive(8'(200 + i), 2'd2, 16'(16'h3300 + i), 16'd9);
        chk("rst_mid_level_before", 64'(o_level_r), 64'd4);
        vcyc.delete();
        rst = 1'b1;
        tick();
        chk("rst_mid_level", 64'(o_level_r), 64'd0);
        chk("rst_mid_vld", 64'(o_upd_vld_r), 64'd0);
        chk("rst_mid_rdy", 64'(o_in_rdy_r), 64'd0);
        sb.delete();
        rst = 1'b0;
        i_busy_r = 1'b0;
        tick();
        chk("rst_mid_rdy_after", 64'(o_in_rdy_r), 64'd1);
        drive(8'd42, 2'd1, 16'h4242, 16'h0042);
        repeat (5) tick();
        chk("rst_mid_init_hold", 64'(vcyc.size()), 64'd0);
        chk("rst_mid_level_one", 64'(o_level_r), 64'd1);
        i_busy_r = 1'b1;
        tick();
        i_busy_r = 1'b0;
        repeat (4) tick();
        chk("rst_mid_after_init", 64'(vcyc.size()), 64'd1);
        chk("rst_mid_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
